alu_pipe: RTL



---
 rtl/alu_pipe_pkg.sv | 66 ++++++
 rtl/alu_pipe_stage.sv | 50 +++++
 rtl/alu_pipe.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared types for the alu_pipe block:
//     alu_op_t    - operation select (ADD, SUB, MULU, MULS)
//     alu_state_t - coarse pipeline state reported to the monitor
//     alu_ref()   - single-cycle reference result, used by scoreboards
//   alu_ref() works on operands up to 64 bits wide; the width of the
//   instance under test is passed as argument w and the result is masked
//   to 2*w bits.
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MULU = 2'd2,
    MULS = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALL = 2'd2
  } alu_state_t;

  localparam int REF_MAX_W = 64;

  // Straightforward full-width arithmetic at 128 bits; SUB and MULS rely on
  // 128-bit wraparound giving the correctly sign-extended value before the
  // final 2*w mask.
  function automatic logic [127:0] alu_ref(input alu_op_t op,
                                           input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned w);
    logic [127:0] mask_w;
    logic [127:0] mask_2w;
    logic [127:0] ax;
    logic [127:0] bx;
    logic [127:0] r;
    mask_w  = (128'd1 << w) - 128'd1;
    mask_2w = (128'd1 << (2 * w)) - 128'd1;
    ax      = {64'd0, a} & mask_w;
    bx      = {64'd0, b} & mask_w;
    case (op)
      ADD:  r = ax + bx;
      SUB:  r = ax - bx;
      MULU: r = ax * bx;
      MULS: begin
        if (ax[w-1]) begin
          ax = ax | ~mask_w;
        end else begin
          ax = ax;
        end
        if (bx[w-1]) begin
          bx = bx | ~mask_w;
        end else begin
          bx = bx;
        end
        r = ax * bx;
      end
      default: r = 128'd0;
    endcase
    return r & mask_2w;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// -----------------------------------------------------------------------------
// alu_pipe_stage
//   One valid/data register of the alu_pipe pipeline.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset (clears valid and data)
//     i_flush   - clears the valid bit, data keeps its (stale) value
//     i_hold    - freezes valid and data (downstream stall)
//     i_valid   - valid from the previous stage / accept strobe
//     i_data    - payload from the previous stage
//     o_valid   - registered valid
//     o_data    - registered payload
// -----------------------------------------------------------------------------
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_hold,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Stage register: reset beats flush, flush beats hold. Data only loads
  // with a valid entry so an empty stage keeps its last payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Runtime-selectable integer ALU (ADD, SUB, MULU, MULS) in a fixed-latency
//   elastic pipeline of LAT stages, the last stage being the output register.
//   Ports:
//     clk, rst             - clock, synchronous active-high reset
//     in_valid / in_ready  - input handshake (in_ready = !stall && !flush)
//     op, a, b, tag        - operation, operands, user tag
//     out_valid / out_ready- output handshake
//     result, out_tag      - 2*WIDTH result and its tag
//     flush                - drops every in-flight operation
//     state                - IDLE / BUSY / STALL
//     inflight             - number of valid stage entries
//     status (optional)    - {zero, negative, carry, overflow}, present only
//                            when ALU_PIPE_STATUS_EN is defined
//   Multiplication: operands are extended to 2*WIDTH (sign-extended for MULS)
//   and B is split in halves. Stage 1 holds a*b_lo (2*WIDTH bits) and the low
//   WIDTH bits of a*b_hi; stage 2 adds them. ADD/SUB results ride in the low
//   partial with a zero high partial.
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  alu_op_t                    op,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [TAG_W-1:0]           tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         result,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       flush,
  output alu_state_t                 state,
  output logic [$clog2(LAT+1)-1:0]   inflight
`ifdef ALU_PIPE_STATUS_EN
  ,
  output logic [3:0]                 status
`endif
);

`ifdef ALU_PIPE_STATUS_EN
  // partial payload: {op, add/sub overflow, tag, lo, hi}
  localparam int PP_W  = 3 + TAG_W + 3 * WIDTH;
  localparam int FIN_W = 2 * WIDTH + TAG_W + 4;
`else
  // partial payload: {tag, lo, hi}
  localparam int PP_W  = TAG_W + 3 * WIDTH;
  localparam int FIN_W = 2 * WIDTH + TAG_W;
`endif
  localparam int CNT_W = $clog2(LAT + 1);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic             w_out_valid;
  logic [FIN_W-1:0] w_out_data;
  logic             w_stall;
  logic             w_accept;
  logic             w_out_hs;
  logic [CNT_W-1:0] r_inflight;

  assign w_stall  = w_out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~flush & ~rst;
  assign w_accept = in_valid & in_ready;
  assign w_out_hs = w_out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Input-side arithmetic (partial results)
  // ---------------------------------------------------------------------------
  logic                 w_signed;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_b_lo;
  logic [2*WIDTH-1:0]   w_pp_lo;
  logic [WIDTH-1:0]     w_pp_hi;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_p1_lo;
  logic [WIDTH-1:0]     w_p1_hi;
  logic [PP_W-1:0]      w_p1;

  assign w_signed = (op == MULS);
  assign w_a_ext  = {{WIDTH{w_signed & a[WIDTH-1]}}, a};
  assign w_b_ext  = {{WIDTH{w_signed & b[WIDTH-1]}}, b};
  assign w_b_lo   = {{WIDTH{1'b0}}, w_b_ext[WIDTH-1:0]};
  // Only the low WIDTH bits of a*b_hi survive the shift by WIDTH.
  assign w_pp_lo  = w_a_ext * w_b_lo;
  assign w_pp_hi  = w_a_ext[WIDTH-1:0] * w_b_ext[2*WIDTH-1:WIDTH];
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = {1'b0, a} - {1'b0, b};

  // Select the partial pair that stage 1 captures for the offered op.
  always_comb begin
    w_p1_lo = '0;
    w_p1_hi = '0;
    case (op)
      ADD: begin
        w_p1_lo = {{(WIDTH-1){1'b0}}, w_sum};
        w_p1_hi = '0;
      end
      SUB: begin
        w_p1_lo = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
        w_p1_hi = '0;
      end
      MULU, MULS: begin
        w_p1_lo = w_pp_lo;
        w_p1_hi = w_pp_hi;
      end
      default: begin
        w_p1_lo = '0;
        w_p1_hi = '0;
      end
    endcase
  end

`ifdef ALU_PIPE_STATUS_EN
  logic w_ovf_as;

  // Signed WIDTH-bit overflow for ADD/SUB, judged from operand and result signs.
  always_comb begin
    w_ovf_as = 1'b0;
    case (op)
      ADD:     w_ovf_as = (a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1]  != a[WIDTH-1]);
      SUB:     w_ovf_as = (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);
      default: w_ovf_as = 1'b0;
    endcase
  end

  assign w_p1 = {op, w_ovf_as, tag, w_p1_lo, w_p1_hi};

  // Flags derived from the completed result; carry is bit WIDTH for both
  // ADD (carry-out) and SUB (borrow of the WIDTH+1-bit difference).
  function automatic logic [3:0] status_flags(input logic [1:0]         f_op,
                                              input logic [2*WIDTH-1:0] f_res,
                                              input logic               f_ovf_as);
    logic         f_z;
    logic         f_n;
    logic         f_c;
    logic         f_v;
    logic [WIDTH:0] f_top;
    f_top = f_res[2*WIDTH-1:WIDTH-1];
    f_z   = (f_res == '0);
    f_n   = 1'b0;
    f_c   = 1'b0;
    f_v   = 1'b0;
    case (alu_op_t'(f_op))
      ADD: begin
        f_c = f_res[WIDTH];
        f_v = f_ovf_as;
      end
      SUB: begin
        f_n = f_res[2*WIDTH-1];
        f_c = f_res[WIDTH];
        f_v = f_ovf_as;
      end
      MULS: begin
        f_n = f_res[2*WIDTH-1];
        // representable in WIDTH signed bits iff the top WIDTH+1 bits agree
        f_v = ~((&f_top) | ~(|f_top));
      end
      default: begin
        f_n = 1'b0;
      end
    endcase
    return {f_z, f_n, f_c, f_v};
  endfunction
`else
  assign w_p1 = {tag, w_p1_lo, w_p1_hi};
`endif

  // Combine the partials into the final payload {result, tag[, status]}.
  function automatic logic [FIN_W-1:0] finalize(input logic [PP_W-1:0] p);
    logic [TAG_W-1:0]   f_tag;
    logic [2*WIDTH-1:0] f_lo;
    logic [WIDTH-1:0]   f_hi;
    logic [2*WIDTH-1:0] f_res;
`ifdef ALU_PIPE_STATUS_EN
    logic [1:0]         f_op;
    logic               f_ovf;
    {f_op, f_ovf, f_tag, f_lo, f_hi} = p;
`else
    {f_tag, f_lo, f_hi} = p;
`endif
    f_res = f_lo + {f_hi, {WIDTH{1'b0}}};
`ifdef ALU_PIPE_STATUS_EN
    return {f_res, f_tag, status_flags(f_op, f_res, f_ovf)};
`else
    return {f_res, f_tag};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Stage chain
  // ---------------------------------------------------------------------------
  generate
    if (LAT == 1) begin : g_lat1
      alu_pipe_stage #(.DW(FIN_W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_hold  (w_stall),
        .i_valid (w_accept),
        .i_data  (finalize(w_p1)),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
      );
    end else begin : g_latn
      logic             w_s1_valid;
      logic [PP_W-1:0]  w_s1_data;
      logic             w_fv [2:LAT];
      logic [FIN_W-1:0] w_fd [2:LAT];

      alu_pipe_stage #(.DW(PP_W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_hold  (w_stall),
        .i_valid (w_accept),
        .i_data  (w_p1),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_data)
      );

      alu_pipe_stage #(.DW(FIN_W)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_hold  (w_stall),
        .i_valid (w_s1_valid),
        .i_data  (finalize(w_s1_data)),
        .o_valid (w_fv[2]),
        .o_data  (w_fd[2])
      );

      for (genvar k = 3; k <= LAT; k++) begin : g_tail
        alu_pipe_stage #(.DW(FIN_W)) u_stage (
          .clk     (clk),
          .rst     (rst),
          .i_flush (flush),
          .i_hold  (w_stall),
          .i_valid (w_fv[k-1]),
          .i_data  (w_fd[k-1]),
          .o_valid (w_fv[k]),
          .o_data  (w_fd[k])
        );
      end

      assign w_out_valid = w_fv[LAT];
      assign w_out_data  = w_fd[LAT];
    end
  endgenerate

  assign out_valid = w_out_valid;
  assign result    = w_out_data[FIN_W-1 -: 2*WIDTH];
  assign out_tag   = w_out_data[FIN_W-2*WIDTH-1 -: TAG_W];
`ifdef ALU_PIPE_STATUS_EN
  assign status    = w_out_data[3:0];
`endif

  // ---------------------------------------------------------------------------
  // Occupancy and coarse state
  // ---------------------------------------------------------------------------
  // Occupancy counter; stalls freeze every stage, so it equals the number of
  // valid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (flush) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_out_hs})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign inflight = r_inflight;

  // State decode from occupancy and the live stall condition.
  always_comb begin
    state = IDLE;
    if (r_inflight == '0) begin
      state = IDLE;
    end else if (w_stall) begin
      state = STALL;
    end else begin
      state = BUSY;
    end
  end

endmodule
